// File: rtl/coa_pipe.sv
// Pipelined three-operand arithmetic unit with per-beat mode select, saturating accumulator
// and valid/ready flow control on both sides.
module coa_pipe #(
   parameter  int unsigned W      = 5,
   parameter  int unsigned STAGES = 3,
   localparam int unsigned OW     = 2 * W + 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_in,
   output logic          ready_in,
   input  logic [W-1:0]  A,
   input  logic [W-1:0]  B,
   input  logic [W-1:0]  C,
   input  logic [1:0]    mode,
   output logic          valid_out,
   input  logic          ready_out,
   output logic [OW-1:0] D
);

   // Ranks ahead of the output rank; the output rank is valid_out/D itself.
   localparam int unsigned NR = STAGES - 1;

   logic          stall;
   logic [NR-1:0] vld_q;
   logic [1:0]    mode_q [NR];
   logic [OW-1:0] val_q  [NR];
   logic [OW-1:0] acc_q;

   logic [OW-1:0] a_x, b_x, c_x, ab, r1_val;
   logic [OW:0]   acc_sum;
   logic [OW-1:0] acc_sat;
   logic          is_acc;
   logic [OW-1:0] res;

   assign stall    = valid_out & ~ready_out;
   assign ready_in = ~stall;

   // Rank 1 resolves modes 0-2 completely; mode 3 carries A*B for the accumulator.
   always_comb begin
      a_x    = OW'(A);
      b_x    = OW'(B);
      c_x    = OW'(C);
      ab     = a_x * b_x;
      r1_val = ab;
      unique case (mode)
         2'd0: r1_val = ab + c_x;
         2'd1: r1_val = (a_x + b_x) * c_x;
         2'd2: r1_val = (ab >= c_x) ? ab - c_x : '0;
         2'd3: r1_val = ab;
         default: r1_val = ab;
      endcase
   end

   always_comb begin
      acc_sum = {1'b0, acc_q} + {1'b0, val_q[NR-1]};
      acc_sat = acc_sum[OW] ? '1 : acc_sum[OW-1:0];
      is_acc  = vld_q[NR-1] && (mode_q[NR-1] == 2'd3);
      res     = is_acc ? acc_sat : val_q[NR-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q     <= '0;
         valid_out <= 1'b0;
         D         <= '0;
         acc_q     <= '0;
         for (int i = 0; i < int'(NR); i++) begin
            mode_q[i] <= '0;
            val_q[i]  <= '0;
         end
      end else if (!stall) begin
         vld_q[0] <= valid_in;
         if (valid_in) begin
            mode_q[0] <= mode;
            val_q[0]  <= r1_val;
         end
         for (int i = 1; i < int'(NR); i++) begin
            vld_q[i]  <= vld_q[i-1];
            mode_q[i] <= mode_q[i-1];
            val_q[i]  <= val_q[i-1];
         end
         valid_out <= vld_q[NR-1];
         if (vld_q[NR-1]) begin
            D <= res;
         end
         if (is_acc) begin
            acc_q <= acc_sat;
         end
      end
   end

endmodule
